// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the two buses of the load/store unit: the core-facing request and
// response signals, and the word-wide port to data_memory.
//
//   Core request : in_req_valid, in_is_store, in_funct3, in_address,
//                  in_store_data
//   Core response: out_busy, out_done, out_load_data, out_misaligned,
//                  out_illegal
//   Memory port  : out_mem_address, out_mem_write_data, out_mem_write_enable,
//                  in_mem_read_data (combinational read of out_mem_address)
//
// Modports:
//   slave  - the load/store unit itself
//   master - the environment around it (core plus data memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int MEM_ADDR_WIDTH = 32
);
    logic                      in_req_valid;
    logic                      in_is_store;
    logic [2:0]                in_funct3;
    logic [31:0]               in_address;
    logic [31:0]               in_store_data;

    logic                      out_busy;
    logic                      out_done;
    logic [31:0]               out_load_data;
    logic                      out_misaligned;
    logic                      out_illegal;

    logic [MEM_ADDR_WIDTH-1:0] out_mem_address;
    logic [31:0]               out_mem_write_data;
    logic                      out_mem_write_enable;
    logic [31:0]               in_mem_read_data;

    modport slave (
        input  in_req_valid, in_is_store, in_funct3, in_address, in_store_data,
        input  in_mem_read_data,
        output out_busy, out_done, out_load_data, out_misaligned, out_illegal,
        output out_mem_address, out_mem_write_data, out_mem_write_enable
    );

    modport master (
        output in_req_valid, in_is_store, in_funct3, in_address, in_store_data,
        output in_mem_read_data,
        input  out_busy, out_done, out_load_data, out_misaligned, out_illegal,
        input  out_mem_address, out_mem_write_data, out_mem_write_enable
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns RV32I byte-addressed loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW)
// into accesses on a word-indexed, word-wide data memory. Sub-word stores
// are performed as read-modify-write; loads are byte/half extracted and
// sign- or zero-extended. The core stalls while out_busy is high.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low reset (0 = reset)
//   bus    - load_store_unit_if.slave: core request/response and the
//            data_memory port (see the interface file for signal list)
//
// State flow: IDLE -> (READ) -> (WRITE) -> DONE -> IDLE
//   faults : IDLE -> DONE
//   loads  : IDLE -> READ -> DONE
//   SW     : IDLE -> WRITE -> DONE
//   SB/SH  : IDLE -> READ -> WRITE -> DONE
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]                offset_q, offset_d;
    logic [2:0]                funct3_q, funct3_d;
    logic                      is_store_q, is_store_d;
    logic [31:0]               store_data_q, store_data_d;
    logic [31:0]               word_q, word_d;
    logic [31:0]               load_data_q, load_data_d;
    logic                      misaligned_q, misaligned_d;
    logic                      illegal_q, illegal_d;

    logic                      req_illegal;
    logic                      req_misaligned;
    logic                      req_is_word_store;

    // Shift the addressed byte/half down to bit 0, then extend by funct3.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        case (f3)
            3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  result = {24'h0, shifted[7:0]};
            3'b101:  result = {16'h0, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

    // Overlay the store byte/half onto the word just read from memory.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] result;
        result = old_word;
        if (f3[1:0] == 2'b00) begin
            result[{off, 3'b000} +: 8] = data[7:0];
        end else begin
            result[{off[1], 4'b0000} +: 16] = data[15:0];
        end
        return result;
    endfunction

    // Request classification. Illegal takes priority over misalignment; once
    // illegal encodings are excluded, funct3[1:0] alone gives the size.
    always_comb begin
        req_illegal = (bus.in_funct3 == 3'b011) ||
                      (bus.in_funct3[2:1] == 2'b11) ||
                      (bus.in_is_store && bus.in_funct3[2]);
        req_misaligned = ((bus.in_funct3[1:0] == 2'b01) && bus.in_address[0]) ||
                         ((bus.in_funct3[1:0] == 2'b10) && (bus.in_address[1:0] != 2'b00));
        req_is_word_store = bus.in_is_store && (bus.in_funct3[1:0] == 2'b10);
    end

    // Next-state logic. A request is latched only in IDLE, so in_req_valid
    // seen in any other state is simply dropped. The word register carries
    // the outgoing write word into WRITE: store data for SW, the merged word
    // for SB/SH. Load data is formed straight from the memory read so it is
    // already valid on entry to DONE.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        offset_d     = offset_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        store_data_d = store_data_q;
        word_d       = word_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;

        case (state_q)
            IDLE: begin
                if (bus.in_req_valid) begin
                    mem_addr_d   = MEM_ADDR_WIDTH'(bus.in_address >> 2);
                    offset_d     = bus.in_address[1:0];
                    funct3_d     = bus.in_funct3;
                    is_store_d   = bus.in_is_store;
                    store_data_d = bus.in_store_data;
                    illegal_d    = req_illegal;
                    misaligned_d = !req_illegal && req_misaligned;
                    if (req_illegal || req_misaligned) begin
                        state_d = DONE;
                    end else if (req_is_word_store) begin
                        word_d  = bus.in_store_data;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (is_store_q) begin
                    word_d  = merge_store(bus.in_mem_read_data, store_data_q,
                                          offset_q, funct3_q);
                    state_d = WRITE;
                end else begin
                    word_d      = bus.in_mem_read_data;
                    load_data_d = extract_load(bus.in_mem_read_data, offset_q,
                                               funct3_q);
                    state_d     = DONE;
                end
            end
            WRITE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state lives here; the asynchronous reset clears everything so the
    // write strobe and handshake outputs collapse the moment reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            offset_q     <= '0;
            funct3_q     <= '0;
            is_store_q   <= 1'b0;
            store_data_q <= '0;
            word_q       <= '0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            offset_q     <= offset_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            store_data_q <= store_data_d;
            word_q       <= word_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
        end
    end

    // Outputs are pure decodes of registered state; fault flags are only
    // exposed together with out_done.
    assign bus.out_busy             = (state_q != IDLE);
    assign bus.out_done             = (state_q == DONE);
    assign bus.out_misaligned       = (state_q == DONE) && misaligned_q;
    assign bus.out_illegal          = (state_q == DONE) && illegal_q;
    assign bus.out_load_data        = load_data_q;
    assign bus.out_mem_address      = mem_addr_q;
    assign bus.out_mem_write_enable = (state_q == WRITE);
    assign bus.out_mem_write_data   = (state_q == WRITE) ? word_q : 32'h0;

endmodule
